tilelink_requester: RTL

Single-outstanding TileLink-UL requester that turns a simple host-side read/write request into one `tilelink_a` beat and waits for the matching `tilelink_d` beat. It sits directly upstream of `test_reg` and similar single-register devices: its `bus_tla` output drives their `tick_tla`, and their `bus_tld` feeds its `tick_tld`. It returns read data and error status to the host and applies a bounded response timeout.

---
 rtl/tilelink_requester.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tilelink_requester.sv
// tilelink_requester: single-outstanding TileLink-UL requester.
// Accepts one host read/write, issues a single A-channel beat, waits for the
// matching D-channel beat (or a bounded timeout), then pulses a response.
// The TL package carrying the channel types and opcodes lives here so the
// block is self-contained.

package TL;

    // A-channel opcodes
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic        a_ready;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic [3:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [2:0]  d_size;
        logic [3:0]  d_source;
        logic [3:0]  d_sink;
        logic [31:0] d_data;
        logic        d_error;
    } tilelink_d;

endpackage

module tilelink_requester
    import TL::*;
#(
    // WAIT cycles without d_valid before an error response is forced (1..255)
    parameter int timeout = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output tilelink_a   bus_tla,
    input  tilelink_d   tick_tld
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Counter value on which the last WAIT cycle sits. The counter is 8 bits,
    // so a timeout above 255 is not representable and is treated as 255.
    localparam int  TMO_EFF  = (timeout > 255) ? 255 : ((timeout < 1) ? 1 : timeout);
    localparam logic [7:0] CNT_LAST = 8'(TMO_EFF - 1);

    state_t     state;
    logic [7:0] count;
    tilelink_a  a_q;

    // Responder identity and opcode are not checked; single outstanding
    // request means any D beat in WAIT is ours.
    logic unused_d_fields;
    assign unused_d_fields = ^{tick_tld.d_opcode, tick_tld.d_param,
                               tick_tld.d_size, tick_tld.d_source,
                               tick_tld.d_sink};

    // Full-lane writes use PutFullData, anything narrower is partial.
    function automatic logic [2:0] put_opcode(input logic [3:0] mask);
        return (mask == 4'hF) ? PutFullData : PutPartialData;
    endfunction

    // Host handshake is a pure decode of state so a held request is taken
    // on the first IDLE cycle.
    assign req_ready = (state == IDLE);

    assign bus_tla = a_q;

    // Request FSM. A-channel fields are loaded on accept so the beat is
    // already on the bus during REQ; they then hold until the next accept.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            a_q         <= '0;
            a_q.a_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state         <= REQ;
                        a_q.a_valid   <= 1'b1;
                        a_q.a_address <= req_addr;
                        a_q.a_size    <= 3'd2;
                        a_q.a_source  <= '0;
                        a_q.a_param   <= '0;
                        if (req_write) begin
                            a_q.a_opcode <= put_opcode(req_mask);
                            a_q.a_mask   <= req_mask;
                            a_q.a_data   <= req_wdata;
                        end else begin
                            a_q.a_opcode <= Get;
                            a_q.a_mask   <= 4'hF;
                            a_q.a_data   <= '0;
                        end
                    end
                end

                REQ: begin
                    a_q.a_valid <= 1'b0;
                    count       <= '0;
                    state       <= WAIT;
                end

                WAIT: begin
                    // A real response arriving on the last cycle beats the timeout.
                    if (tick_tld.d_valid) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= tick_tld.d_data;
                        resp_error <= tick_tld.d_error;
                        state      <= RESP;
                    end else if (count == CNT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_error <= 1'b1;
                        state      <= RESP;
                    end else if (count != 8'hFF) begin
                        count <= count + 8'd1;
                    end
                end

                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
